// File: rtl/cnt_sched_pkg.sv
// Shared types and default sizing for the counter scheduler.
// States, default counter width and default requester count.
package cnt_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/cnt_sched_cnt_core.sv
// Shared up-counter: reset beats load, load beats enable, otherwise hold.
module cnt_core #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out
);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_reg <= '0;
    else if (load)
      cnt_reg <= cnt_in;
    else if (enab)
      cnt_reg <= cnt_reg + WIDTH'(1);
  end

  assign cnt_out = cnt_reg;

endmodule

// File: rtl/cnt_sched.sv
// Arbitrates requesters onto one shared counter and runs each job to its length.
// Define CNT_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      cnt_out
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state_reg, state_next;
  logic [NREQ-1:0]  gnt_reg;
  logic [WIDTH-1:0] len_lat_reg;
  logic [IW-1:0]    win_idx;
  logic             win_found;
  logic             grant_now;
  logic             load, enab;
  logic [WIDTH-1:0] cnt_in;

`ifdef CNT_SCHED_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is the last assignment.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx   = IW'(i);
        win_found = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] rr_ptr_reg;

  // Scan offsets far-to-near so the index right after the last winner wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(rr_ptr_reg) + k) % NREQ]) begin
        win_idx   = IW'((int'(rr_ptr_reg) + k) % NREQ);
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr_reg <= IW'(NREQ - 1);
    else if (grant_now)
      rr_ptr_reg <= win_idx;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    grant_now  = 1'b0;
    load       = 1'b0;
    enab       = 1'b0;
    cnt_in     = '0;
    case (state_reg)
      S_IDLE: begin
        if (win_found) begin
          grant_now  = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        load       = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        // Stop exactly at the target so a full-scale length never wraps.
        if (cnt_out != len_lat_reg)
          enab = 1'b1;
        else
          state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_reg     <= '0;
      len_lat_reg <= '0;
    end else if (grant_now) begin
      gnt_reg     <= NREQ'(1) << win_idx;
      len_lat_reg <= len[int'(win_idx)*WIDTH +: WIDTH];
    end else if (state_reg == S_DONE) begin
      gnt_reg <= '0;
    end
  end

  cnt_core #(.WIDTH(WIDTH)) u_cnt_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .enab    (enab),
    .cnt_in  (cnt_in),
    .cnt_out (cnt_out)
  );

  assign gnt  = gnt_reg;
  assign done = (state_reg == S_DONE) ? gnt_reg : '0;
  assign busy = (state_reg != S_IDLE);

endmodule

// File: tb/tb_cnt_sched.sv
// Directed bench for cnt_sched at WIDTH=5, NREQ=4; one line per job.
module tb_cnt_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [19:0] len;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [4:0]  cnt_out;

  int n_cmp;
  int n_bad;

  cnt_sched #(.WIDTH(5), .NREQ(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .len     (len),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .cnt_out (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs must already be applied at a negedge in an IDLE cycle (cycle 0).
  // Returns the cycle of the done pulse (0 on timeout), gnt at cycle 1,
  // the first nonzero gnt, and done/cnt_out at the pulse.
  task automatic wait_done(output int cyc, output logic [3:0] gnt1,
                           output logic [3:0] gnt_first,
                           output logic [3:0] done_v, output logic [4:0] cnt_v);
    cyc       = 0;
    gnt1      = 'x;
    gnt_first = '0;
    done_v    = '0;
    cnt_v     = 'x;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) gnt1 = gnt;
      if (gnt_first == 4'b0000) gnt_first = gnt;
      if (done != 4'b0000) begin
        cyc    = c;
        done_v = done;
        cnt_v  = cnt_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    len = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp += 4;
    if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    if (done !== 4'b0000) begin n_bad++; $display("FAIL reset_done got=%b exp=0000", done); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (cnt_out !== 5'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_out); end
    $display("reset: gnt=%b done=%b busy=%b cnt=%0d", gnt, done, busy, cnt_out);
  endtask

  task automatic test_single();
    int cyc; logic [3:0] g1, gf, dv; logic [4:0] cv;
    req = 4'b0100;
    len = '0;
    len[2*5 +: 5] = 5'd3;
    wait_done(cyc, g1, gf, dv, cv);
    req = 4'b0000;
    n_cmp += 4;
    if (g1 !== 4'b0100) begin n_bad++; $display("FAIL single_gnt got=%b exp=0100", g1); end
    if (cyc !== 6) begin n_bad++; $display("FAIL single_latency got=%0d exp=6", cyc); end
    if (dv !== 4'b0100) begin n_bad++; $display("FAIL single_done got=%b exp=0100", dv); end
    if (cv !== 5'd3) begin n_bad++; $display("FAIL single_cnt got=%0d exp=3", cv); end
    @(negedge clk);
    n_cmp += 2;
    if (gnt !== 4'b0000) begin n_bad++; $display("FAIL single_gnt_clear got=%b exp=0000", gnt); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle got=%b exp=0", busy); end
    $display("single: gnt=%b done=%b at cycle %0d cnt=%0d", g1, dv, cyc, cv);
  endtask

  task automatic test_zero_len();
    int cyc; logic [3:0] g1, gf, dv; logic [4:0] cv;
    req = 4'b0001;
    len = '0;
    wait_done(cyc, g1, gf, dv, cv);
    req = 4'b0000;
    n_cmp += 3;
    if (cyc !== 3) begin n_bad++; $display("FAIL zero_latency got=%0d exp=3", cyc); end
    if (dv !== 4'b0001) begin n_bad++; $display("FAIL zero_done got=%b exp=0001", dv); end
    if (cv !== 5'd0) begin n_bad++; $display("FAIL zero_cnt got=%0d exp=0", cv); end
    @(negedge clk);
    $display("zero_len: done=%b at cycle %0d cnt=%0d", dv, cyc, cv);
  endtask

  task automatic test_max_len();
    int cyc; logic [3:0] g1, gf, dv; logic [4:0] cv;
    req = 4'b0010;
    len = '0;
    len[1*5 +: 5] = 5'd31;
    wait_done(cyc, g1, gf, dv, cv);
    req = 4'b0000;
    n_cmp += 3;
    if (cyc !== 34) begin n_bad++; $display("FAIL max_latency got=%0d exp=34", cyc); end
    if (cv !== 5'd31) begin n_bad++; $display("FAIL max_cnt got=%0d exp=31", cv); end
    if (dv !== 4'b0010) begin n_bad++; $display("FAIL max_done got=%b exp=0010", dv); end
    @(negedge clk);
    n_cmp += 1;
    if (cnt_out !== 5'd31) begin n_bad++; $display("FAIL max_nowrap got=%0d exp=31", cnt_out); end
    $display("max_len: done=%b at cycle %0d cnt=%0d", dv, cyc, cv);
  endtask

  task automatic test_mid_reset();
    int seen_done;
    req = 4'b1000;
    len = '0;
    len[3*5 +: 5] = 5'd20;
    repeat (10) @(negedge clk);
    n_cmp += 1;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_running got=%b exp=1", busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req = 4'b0000;
    n_cmp += 4;
    if (gnt !== 4'b0000) begin n_bad++; $display("FAIL midrst_gnt got=%b exp=0000", gnt); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (cnt_out !== 5'd0) begin n_bad++; $display("FAIL midrst_cnt got=%0d exp=0", cnt_out); end
    if (done !== 4'b0000) begin n_bad++; $display("FAIL midrst_done got=%b exp=0000", done); end
    seen_done = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done !== 4'b0000) seen_done++;
    end
    n_cmp += 1;
    if (seen_done !== 0) begin n_bad++; $display("FAIL midrst_no_done got=%0d pulses exp=0", seen_done); end
    $display("mid_reset: gnt=%b busy=%b cnt=%0d later_done_pulses=%0d", gnt, busy, cnt_out, seen_done);
  endtask

  task automatic test_round_robin();
    int cyc; logic [3:0] g1, gf, dv; logic [4:0] cv;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_bit;
    // Pointer was reset by the preceding test, so index 0 is searched first.
    req = 4'b1111;
    len = {5'd1, 5'd1, 5'd1, 5'd1};
    for (int j = 0; j < 5; j++) begin
      wait_done(cyc, g1, gf, dv, cv);
      exp_bit = 4'b0001 << order[j];
      n_cmp += 3;
      if (gf !== exp_bit) begin n_bad++; $display("FAIL rr_gnt job%0d got=%b exp=%b", j, gf, exp_bit); end
      if (dv !== exp_bit) begin n_bad++; $display("FAIL rr_done job%0d got=%b exp=%b", j, dv, exp_bit); end
      // The first job starts in IDLE; later ones spend one extra IDLE cycle.
      if (cyc !== ((j == 0) ? 4 : 5)) begin
        n_bad++;
        $display("FAIL rr_latency job%0d got=%0d exp=%0d", j, cyc, (j == 0) ? 4 : 5);
      end
      $display("rr job%0d: gnt=%b done=%b after %0d cycles", j, gf, dv, cyc);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    int cyc; logic [3:0] g1, gf, dv; logic [4:0] cv;
    req = 4'b1010;
    len = {5'd1, 5'd1, 5'd1, 5'd1};
    for (int j = 0; j < 4; j++) begin
      wait_done(cyc, g1, gf, dv, cv);
      n_cmp += 2;
      if (gf !== 4'b0010) begin n_bad++; $display("FAIL fp_gnt job%0d got=%b exp=0010", j, gf); end
      if (dv !== 4'b0010) begin n_bad++; $display("FAIL fp_done job%0d got=%b exp=0010", j, dv); end
      $display("fixed job%0d: gnt=%b done=%b after %0d cycles", j, gf, dv, cyc);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    req   = '0;
    len   = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_zero_len();
    test_max_len();
    test_mid_reset();
`ifdef CNT_SCHED_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
